// File: rtl/esc_pwm_generator.sv
// Four servo-style ESC pulses from 8-bit motor rates, gated by arm, a post-reset hold-off and a rate watchdog.
// Latency: a new rate takes effect at the next frame boundary. No backpressure: rate_valid is always accepted.
module esc_pwm_generator #(
   parameter int TICKS_PER_US = 38,
   parameter int FRAME_US     = 2500,
   parameter int MIN_US       = 1000,
   parameter int SPAN_US      = 1000,
   parameter int INIT_FRAMES  = 4,
   parameter int WDOG_FRAMES  = 40
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic [7:0] motor_1_rate,
   input  logic [7:0] motor_2_rate,
   input  logic [7:0] motor_3_rate,
   input  logic [7:0] motor_4_rate,
   input  logic       rate_valid,
   input  logic       arm,
   output logic       motor_1_pwm,
   output logic       motor_2_pwm,
   output logic       motor_3_pwm,
   output logic       motor_4_pwm,
   output logic       frame_start,
   output logic       wdog_tripped
);

   localparam int TICK_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
   localparam int US_W   = $clog2(FRAME_US);
   localparam int INIT_W = $clog2(INIT_FRAMES + 1);
   localparam int WD_W   = $clog2(WDOG_FRAMES + 1);

   localparam logic [1:0] ST_INIT = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;

   logic [TICK_W-1:0]      tick_cnt;
   logic [US_W-1:0]        us_cnt;
   logic [INIT_W-1:0]      init_cnt;
   logic [WD_W-1:0]        wdog_cnt;
   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic [3:0][7:0]        shadow;
   logic [3:0][US_W-1:0]   width;
   logic [3:0][US_W-1:0]   width_nxt;
   logic [3:0][17:0]       prod;
   logic [3:0]             pwm;
   logic [3:0]             pwm_nxt;
   logic                   boundary;
   logic                   tick_wrap;
   logic                   trip_now;
   logic                   gate;

   assign boundary  = (tick_cnt == '0) && (us_cnt == '0);
   assign tick_wrap = (tick_cnt == TICK_W'(TICKS_PER_US - 1));

   // Watchdog state as seen by the boundary being processed; a rate_valid on
   // the same cycle only clears it for the following frame.
   assign trip_now = wdog_tripped ||
                     (boundary && !rate_valid && (wdog_cnt == WD_W'(WDOG_FRAMES - 1)));
   assign gate     = arm && !trip_now;

   always_comb begin
      state_nxt = ST_INIT;
      case (state)
         ST_INIT: state_nxt = (boundary && (init_cnt == INIT_W'(INIT_FRAMES))) ? ST_RUN : ST_INIT;
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_INIT;
      endcase
   end

   always_comb begin
      prod      = '0;
      width_nxt = width;
      pwm_nxt   = '0;
      for (int m = 0; m < 4; m++) begin
         prod[m] = gate ? (18'(shadow[m]) * 18'(SPAN_US)) : 18'd0;
         if (boundary) begin
            width_nxt[m] = US_W'(MIN_US) + US_W'(prod[m] >> 8);
         end
         pwm_nxt[m] = (state_nxt == ST_RUN) && (us_cnt < width_nxt[m]);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         tick_cnt     <= '0;
         us_cnt       <= '0;
         init_cnt     <= '0;
         wdog_cnt     <= '0;
         wdog_tripped <= 1'b0;
         state        <= ST_INIT;
         shadow       <= '0;
         width        <= {4{US_W'(MIN_US)}};
         pwm          <= '0;
         frame_start  <= 1'b0;
      end else begin
         tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
         if (tick_wrap) begin
            us_cnt <= (us_cnt == US_W'(FRAME_US - 1)) ? '0 : us_cnt + 1'b1;
         end

         if (rate_valid) begin
            shadow <= {motor_4_rate, motor_3_rate, motor_2_rate, motor_1_rate};
         end

         if (rate_valid) begin
            wdog_cnt     <= '0;
            wdog_tripped <= 1'b0;
         end else if (boundary && (wdog_cnt != WD_W'(WDOG_FRAMES))) begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_cnt == WD_W'(WDOG_FRAMES - 1)) begin
               wdog_tripped <= 1'b1;
            end
         end

         // init_cnt counts completed hold-off frames
         if ((state == ST_INIT) && boundary && (init_cnt != INIT_W'(INIT_FRAMES))) begin
            init_cnt <= init_cnt + 1'b1;
         end

         state       <= state_nxt;
         width       <= width_nxt;
         pwm         <= pwm_nxt;
         frame_start <= boundary;
      end
   end

   assign motor_1_pwm = pwm[0];
   assign motor_2_pwm = pwm[1];
   assign motor_3_pwm = pwm[2];
   assign motor_4_pwm = pwm[3];

endmodule

// File: tb/tb_esc_pwm_generator.sv
// Bench for esc_pwm_generator with a scaled-down timebase: frame-level model checked every cycle plus directed pulse-width checks.
module tb_esc_pwm_generator;

   localparam int TPU   = 2;
   localparam int FUS   = 60;
   localparam int MIN   = 20;
   localparam int SPAN  = 30;
   localparam int INITF = 4;
   localparam int WDOG  = 12;
   localparam int FR    = TPU * FUS;

   logic       sys_clk = 1'b0;
   logic       reset = 1'b1;
   logic       rate_valid = 1'b0;
   logic       arm = 1'b1;
   logic [7:0] r1 = 8'd0, r2 = 8'd0, r3 = 8'd0, r4 = 8'd0;
   logic       p1, p2, p3, p4, frame_start, wdog_tripped;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 sys_clk = ~sys_clk;

   esc_pwm_generator #(
      .TICKS_PER_US(TPU), .FRAME_US(FUS), .MIN_US(MIN), .SPAN_US(SPAN),
      .INIT_FRAMES(INITF), .WDOG_FRAMES(WDOG)
   ) dut (
      .sys_clk(sys_clk), .reset(reset),
      .motor_1_rate(r1), .motor_2_rate(r2), .motor_3_rate(r3), .motor_4_rate(r4),
      .rate_valid(rate_valid), .arm(arm),
      .motor_1_pwm(p1), .motor_2_pwm(p2), .motor_3_pwm(p3), .motor_4_pwm(p4),
      .frame_start(frame_start), .wdog_tripped(wdog_tripped)
   );

   // Frame-level model: cycle index since reset, frames seen, frames without a rate update.
   int   cyc, nfr, fwr;
   int   m_sh[4];
   int   m_w[4];
   bit   m_run, model_ok = 1'b0, bnd;
   int   off;
   logic [5:0] exp_v;

   function automatic int width_of(input int r);
      return MIN + (r * SPAN) / 256;
   endfunction

   always @(posedge sys_clk) begin
      if (reset) begin
         cyc = 0; nfr = 0; fwr = 0; m_run = 1'b0;
         m_sh = '{default: 0};
         m_w  = '{default: MIN};
         exp_v = '0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         bnd = ((cyc % FR) == 0);
         if (bnd) begin
            nfr++;
            if (nfr > INITF) m_run = 1'b1;
            if (!rate_valid) fwr++;
            for (int m = 0; m < 4; m++)
               m_w[m] = width_of((arm && fwr < WDOG) ? m_sh[m] : 0);
         end
         if (rate_valid) begin
            fwr = 0;
            m_sh[0] = int'(r1); m_sh[1] = int'(r2); m_sh[2] = int'(r3); m_sh[3] = int'(r4);
         end
         off = cyc % FR;
         for (int m = 0; m < 4; m++)
            exp_v[5-m] = m_run && (off < m_w[3-m] * TPU);
         exp_v[1] = bnd;
         exp_v[0] = (fwr >= WDOG);
         cyc++;
      end
   end

   always @(negedge sys_clk) begin
      if (model_ok) begin
         n_cmp++;
         if ({p4, p3, p2, p1, frame_start, wdog_tripped} !== exp_v) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t got pwm4..1,fs,wd=%b required %b", $time,
                     {p4, p3, p2, p1, frame_start, wdog_tripped}, exp_v);
         end
      end
   end

   // Per-frame high-time monitor: last_hi holds the high cycles of the frame that just ended.
   int cur_hi[4];
   int last_hi[4];
   int ncyc = 0, last_fs = 0, fs_gap = 0;

   always @(negedge sys_clk) begin
      ncyc++;
      if (reset) begin
         cur_hi = '{default: 0};
      end else begin
         if (frame_start) begin
            last_hi = cur_hi;
            cur_hi  = '{default: 0};
            fs_gap  = ncyc - last_fs;
            last_fs = ncyc;
         end
         if (p1) cur_hi[0]++;
         if (p2) cur_hi[1]++;
         if (p3) cur_hi[2]++;
         if (p4) cur_hi[3]++;
      end
   end

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic check_hi(input string name, input int e0, input int e1, input int e2, input int e3);
      check({name, "_m1"}, last_hi[0], e0);
      check({name, "_m2"}, last_hi[1], e1);
      check({name, "_m3"}, last_hi[2], e2);
      check({name, "_m4"}, last_hi[3], e3);
   endtask

   task automatic wait_fs();
      int k;
      k = 0;
      do begin
         @(negedge sys_clk);
         k++;
      end while (frame_start !== 1'b1 && k < 2 * FR);
      #1;
      if (frame_start !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_fs: frame_start absent for %0d cycles, required within %0d", k, FR);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
      @(posedge sys_clk);
      #1;
      r1 = a; r2 = b; r3 = c; r4 = d;
      rate_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      rate_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      cycles(3);
      check("reset_outputs", int'({p4, p3, p2, p1, frame_start, wdog_tripped}), 0);
      reset = 1'b0;

      // Hold-off: four low frames, then minimum pulses
      for (int f = 1; f <= 5; f++) begin
         wait_fs();
         if (f >= 2) check_hi("holdoff", 0, 0, 0, 0);
      end
      wait_fs();
      check_hi("idle_min", 40, 40, 40, 40);
      check("frame_period", fs_gap, FR);

      // Rate mapping 0/64/128/255
      cycles(10);
      send(8'd0, 8'd64, 8'd128, 8'd255);
      wait_fs();
      check("rise_together", int'({p4, p3, p2, p1}), 15);
      wait_fs();
      check_hi("rate_map", 40, 54, 70, 98);

      // Mid-pulse update does not disturb the running frame
      cycles(3);
      send(8'd128, 8'd128, 8'd128, 8'd128);
      wait_fs();
      cycles(20);
      send(8'd255, 8'd255, 8'd255, 8'd255);
      wait_fs();
      check_hi("mid_pulse_keep", 70, 70, 70, 70);
      wait_fs();
      check_hi("mid_pulse_next", 98, 98, 98, 98);

      // Disarmed, then armed mid-frame
      cycles(5);
      arm = 1'b0;
      send(8'd200, 8'd200, 8'd200, 8'd200);
      wait_fs();
      cycles(10);
      arm = 1'b1;
      wait_fs();
      check_hi("disarmed", 40, 40, 40, 40);
      wait_fs();
      check_hi("armed", 86, 86, 86, 86);

      // Watchdog: three boundaries already passed since the last rate_valid
      for (int k = 4; k <= WDOG; k++) begin
         wait_fs();
         check($sformatf("wdog_at_%0d", k), int'(wdog_tripped), (k == WDOG) ? 1 : 0);
      end
      check_hi("pre_trip", 86, 86, 86, 86);
      wait_fs();
      check_hi("tripped", 40, 40, 40, 40);
      cycles(15);
      send(8'd200, 8'd200, 8'd200, 8'd200);
      check("wdog_clear", int'(wdog_tripped), 0);
      wait_fs();
      check_hi("tripped_frame", 40, 40, 40, 40);
      wait_fs();
      check_hi("wdog_recover", 86, 86, 86, 86);

      // rate_valid exactly on the boundary cycle
      repeat (FR - 1) @(posedge sys_clk);
      #1;
      r1 = 8'd255; r2 = 8'd255; r3 = 8'd255; r4 = 8'd255;
      rate_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      rate_valid = 1'b0;
      wait_fs();
      check_hi("bnd_prev", 86, 86, 86, 86);
      wait_fs();
      check_hi("bnd_old_shadow", 86, 86, 86, 86);
      wait_fs();
      check_hi("bnd_new_shadow", 98, 98, 98, 98);

      // Reset during a high pulse restarts the hold-off
      cycles(5);
      check("pulse_before_reset", int'({p4, p3, p2, p1}), 15);
      reset = 1'b1;
      cycles(1);
      check("reset_mid_pulse", int'({p4, p3, p2, p1, frame_start, wdog_tripped}), 0);
      reset = 1'b0;
      for (int f = 1; f <= 5; f++) begin
         wait_fs();
         if (f >= 2) check_hi("holdoff2", 0, 0, 0, 0);
      end
      wait_fs();
      check_hi("after_reset_min", 40, 40, 40, 40);

      cycles(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/esc_pwm_generator.md
Name: esc_pwm_generator

Overview:
- Consumer end of the motor-rate interface: takes the four 8-bit motor rates produced by the motor mixer and drives four ESC servo-style PWM outputs.
- Rates are latched only at frame boundaries, so pulses never glitch mid-frame.
- Adds safety gating (arm input, post-reset hold-off, rate watchdog) so a stalled control pipeline or a disarmed state always yields minimum-throttle pulses.

Parameters:
- TICKS_PER_US, 38, sys_clk cycles per microsecond (38 MHz clock).
- FRAME_US, 2500, PWM frame period in us (400 Hz).
- MIN_US, 1000, pulse width for rate 0.
- SPAN_US, 1000, pulse width added at full scale before the >>8.
- INIT_FRAMES, 4, frames of all-low output after reset.
- WDOG_FRAMES, 40, frames without rate_valid before forcing minimum pulses.

Ports:
- sys_clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- motor_1_rate  in  8  unsigned rate, motor 1
- motor_2_rate  in  8  unsigned rate, motor 2
- motor_3_rate  in  8  unsigned rate, motor 3
- motor_4_rate  in  8  unsigned rate, motor 4
- rate_valid  in  1  one-cycle strobe: motor_n_rate inputs are new
- arm  in  1  1 = use rates; 0 = force rate 0
- motor_1_pwm  out  1  ESC pulse, motor 1
- motor_2_pwm  out  1  ESC pulse, motor 2
- motor_3_pwm  out  1  ESC pulse, motor 3
- motor_4_pwm  out  1  ESC pulse, motor 4
- frame_start  out  1  one-cycle pulse at each frame start
- wdog_tripped  out  1  1 while the watchdog forces minimum pulses

Behaviour:
- Reset:
  - All outputs 0.
  - Shadow rates 0; active widths = MIN_US.
  - tick_cnt = 0, us_cnt = 0, frame counters 0.
  - wdog_tripped = 0, state = ST_INIT.
  - Reset asserted mid-pulse drops all PWM outputs low on the next edge.
- Timebase:
  - tick_cnt counts 0..TICKS_PER_US-1.
  - us_cnt advances when tick_cnt wraps and counts 0..FRAME_US-1, then wraps to 0.
  - A frame boundary is tick_cnt==0 and us_cnt==0.
- Shadow capture:
  - On rate_valid, all four rates are registered into shadow regs on the same edge.
  - rate_valid is ignored while reset is high.
- Frame boundary actions (single cycle):
  - frame_start = 1.
  - For each motor, eff_rate = (arm && !wdog_tripped) ? shadow_n : 0.
  - width_n = MIN_US + ((eff_rate * SPAN_US) >> 8), computed in an 18-bit unsigned intermediate.
  - rate 0 -> 1000, rate 128 -> 1500, rate 255 -> 1996.
- FSM states:
  - ST_INIT: all PWM outputs held 0; counts frame boundaries. At the INIT_FRAMES-th boundary -> ST_RUN, and that boundary loads widths.
  - ST_RUN: motor_n_pwm = (us_cnt < width_n), registered. PWM goes high 1 cycle after the frame boundary and stays high for exactly width_n*TICKS_PER_US cycles.
  - No other transitions exist except reset. Illegal encoding -> ST_INIT.
- Latency: a rate presented with rate_valid affects the output at the next frame boundary at least 1 cycle later.
- Simultaneous events:
  - rate_valid on the boundary cycle: the old shadow is used for this frame, the new one for the next.
  - arm changes take effect only at a boundary.
  - Widths never change mid-frame.
- Watchdog:
  - wdog_cnt increments at each boundary and clears on rate_valid.
  - When wdog_cnt reaches WDOG_FRAMES, wdog_tripped = 1 (saturates; no wrap).
  - The first rate_valid afterward clears wdog_cnt and wdog_tripped on the next edge. Nonzero widths resume at the following boundary.
  - The watchdog also counts during ST_INIT.
- Guarantees: width_n is always ≤ MIN_US+SPAN_US < FRAME_US, so each frame always has a low gap.

Test Plan:
- Reset then idle, arm=1, no rate_valid -> PWM low for the first 4 frames (4*95000 cycles). Then 1000 us pulses (38000 cycles high). frame_start period is 95000 cycles.
- arm=1, rate_valid with rates 0/64/128/255 -> at the next boundary, high times are 38000/47500/57000/75848 cycles. All four outputs rise on the same cycle.
- rate_valid with 255 arriving mid-frame, during an active 1500 us pulse -> the current pulse still ends at 57000 cycles; the next frame is 75848 cycles.
- arm=0 with rates 200 -> 1000 us pulses. arm=1 mid-frame -> change appears only at the next frame_start, 1781 us (67678 cycles).
- Stop rate_valid for 40 frames -> wdog_tripped rises at the 40th boundary and pulses drop to 1000 us. One rate_valid -> wdog_tripped clears next cycle; programmed widths return at the next boundary.
- Assert reset for 1 cycle during a high pulse -> all PWM outputs 0 next cycle, frame_start 0, ST_INIT hold-off restarts (4 frames low).
